// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : riscv_pkg
//  Purpose  : Shared RV32 definitions for the fetch stage: datapath width,
//             the canonical NOP encoding and the fetch FSM state type.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  // addi x0, x0, 0
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

endpackage : riscv_pkg
`default_nettype wire

// File: rtl/if_id_reg.sv
`default_nettype none
// ============================================================================
//  Module   : if_id_reg
//  Purpose  : IF/ID pipeline slot: valid flag, instruction word, its PC and
//             PC+4. Load captures a new fetch, flush invalidates the slot and
//             parks a NOP in it, otherwise the contents are held.
//  Ports    : clk, reset (async, active-low)
//             load_i, flush_i          slot controls (flush wins)
//             instr_i, pc_i            fetched word and its address
//             valid_o, instr_o, pc_o, pc_plus4_o   registered slot contents
//  Revision : 1.0  initial release
// ============================================================================
module if_id_reg #(
  parameter int unsigned            XLEN      = 32,
  parameter logic [XLEN-1:0]        NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] instr_i,
  input  logic [XLEN-1:0] pc_i,
  output logic            valid_o,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_plus4_o
);

  localparam logic [XLEN-1:0] c_FOUR = XLEN'(4);

  logic            valid_q,    valid_d;
  logic [XLEN-1:0] instr_q,    instr_d;
  logic [XLEN-1:0] pc_q,       pc_d;
  logic [XLEN-1:0] pc_plus4_q, pc_plus4_d;

  always_comb begin
    valid_d    = valid_q;
    instr_d    = instr_q;
    pc_d       = pc_q;
    pc_plus4_d = pc_plus4_q;
    if (flush_i) begin
      // PC fields keep their last value; only valid/instr are meaningful.
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
    end else if (load_i) begin
      valid_d    = 1'b1;
      instr_d    = instr_i;
      pc_d       = pc_i;
      pc_plus4_d = pc_i + c_FOUR;   // wraps modulo 2^XLEN
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q    <= 1'b0;
      instr_q    <= NOP_INSTR;
      pc_q       <= '0;
      pc_plus4_q <= '0;
    end else begin
      valid_q    <= valid_d;
      instr_q    <= instr_d;
      pc_q       <= pc_d;
      pc_plus4_q <= pc_plus4_d;
    end
  end

  assign valid_o    = valid_q;
  assign instr_o    = instr_q;
  assign pc_o       = pc_q;
  assign pc_plus4_o = pc_plus4_q;

endmodule : if_id_reg
`default_nettype wire

// File: rtl/instruction_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : instruction_fetch_stage
//  Purpose  : RV32 fetch stage. Owns the PC, presents it combinationally to
//             instruction memory, captures the returned word into the IF/ID
//             slot under a valid/ready handshake, and handles redirects and
//             fetch faults (misaligned or out-of-range PC).
//  Ports    : clk, reset (async, active-low)
//             imem_addr (out) / imem_rd (in)      instruction memory
//             redirect_valid, redirect_pc (in)     PC change from execute
//             id_ready (in), id_valid, id_instr, id_pc, id_pc_plus4 (out)
//             fetch_fault (out, sticky), fetch_count (out, delivered words)
//  Revision : 1.0  initial release
// ============================================================================
module instruction_fetch_stage #(
  parameter logic [riscv_pkg::XLEN-1:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned                IMEM_BYTES = 32,
  parameter logic [riscv_pkg::XLEN-1:0] NOP_INSTR  = riscv_pkg::NOP_INSTR
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic [riscv_pkg::XLEN-1:0] imem_addr,
  input  logic [riscv_pkg::XLEN-1:0] imem_rd,
  input  logic                       redirect_valid,
  input  logic [riscv_pkg::XLEN-1:0] redirect_pc,
  input  logic                       id_ready,
  output logic                       id_valid,
  output logic [riscv_pkg::XLEN-1:0] id_instr,
  output logic [riscv_pkg::XLEN-1:0] id_pc,
  output logic [riscv_pkg::XLEN-1:0] id_pc_plus4,
  output logic                       fetch_fault,
  output logic [riscv_pkg::XLEN-1:0] fetch_count
);

  import riscv_pkg::*;

  // Highest byte address at which a full word still fits in memory.
  localparam logic [XLEN-1:0] c_LAST_PC = XLEN'(IMEM_BYTES - 4);
  localparam logic [XLEN-1:0] c_FOUR    = XLEN'(4);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q,    pc_d;
  logic            fault_q, fault_d;
  logic [XLEN-1:0] count_q;

  logic slot_load;
  logic slot_flush;
  logic adv;
  logic pc_bad;
  logic handshake;

  // Slot can take a new word when it is empty or being consumed this cycle.
  assign adv       = !id_valid || id_ready;
  assign handshake = id_valid && id_ready;
  assign pc_bad    = (pc_q[1:0] != 2'b00) || (pc_q > c_LAST_PC);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    fault_d    = fault_q;
    slot_load  = 1'b0;
    slot_flush = 1'b0;

    if (redirect_valid) begin
      // Redirect overrides everything, including a stalled slot; the target
      // is fetched (and fault-checked) on the following cycle.
      pc_d       = redirect_pc;
      slot_flush = 1'b1;
      state_d    = RUN;
    end else begin
      unique case (state_q)
        BOOT: state_d = RUN;
        RUN: begin
          if (adv) begin
            if (pc_bad) begin
              slot_flush = 1'b1;
              fault_d    = 1'b1;
              state_d    = HALT;
            end else begin
              slot_load = 1'b1;
              pc_d      = pc_q + c_FOUR;
            end
          end
        end
        HALT: state_d = HALT;
        default: state_d = BOOT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      fault_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      fault_q <= fault_d;
      // A handshake coinciding with a redirect still counts as delivered.
      if (handshake) begin
        count_q <= count_q + 1'b1;
      end
    end
  end

  if_id_reg #(
    .XLEN      (XLEN),
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .clk        (clk),
    .reset      (reset),
    .load_i     (slot_load),
    .flush_i    (slot_flush),
    .instr_i    (imem_rd),
    .pc_i       (pc_q),
    .valid_o    (id_valid),
    .instr_o    (id_instr),
    .pc_o       (id_pc),
    .pc_plus4_o (id_pc_plus4)
  );

  assign imem_addr   = pc_q;
  assign fetch_fault = fault_q;
  assign fetch_count = count_q;

endmodule : instruction_fetch_stage
`default_nettype wire

// File: tb/tb_instruction_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instruction_fetch_stage
//  Purpose  : Self-checking bench for instruction_fetch_stage. The stimulus
//             process pushes the words it expects decode to receive; a
//             monitor pops one entry per handshake and compares it. Direct
//             checks cover reset, stall, flush, fault and counter values.
//  Revision : 1.0  initial release
// ============================================================================
module tb_instruction_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        reset;
  logic [31:0] imem_addr;
  logic [31:0] imem_rd;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
  logic        fetch_fault;
  logic [31:0] fetch_count;

  instruction_fetch_stage #(
    .RESET_PC   (32'h0),
    .IMEM_BYTES (32),
    .NOP_INSTR  (NOP)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_rd        (imem_rd),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_ready       (id_ready),
    .id_valid       (id_valid),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
    .id_pc_plus4    (id_pc_plus4),
    .fetch_fault    (fetch_fault),
    .fetch_count    (fetch_count)
  );

  // Instruction memory, combinational read.
  logic [31:0] mem [8];
  initial begin
    mem[0] = 32'h0094_0333;
    mem[1] = 32'h4139_03b3;
    mem[2] = 32'h035a_02b3;
    mem[3] = 32'h00a0_0093;
    mem[4] = 32'h0019_ceb3;
    mem[5] = 32'h0020_8133;
    mem[6] = 32'h4011_0193;
    mem[7] = 32'h0041_a233;
  end
  assign imem_rd = (imem_addr < 32'd32) ? mem[imem_addr[4:2]] : 32'hDEAD_BEEF;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h required %h", name, got, exp);
  endtask

  // Scoreboard: expected {instr, pc} pairs in delivery order.
  typedef struct { logic [31:0] instr; logic [31:0] pc; } exp_t;
  exp_t sb[$];

  task automatic push(input logic [31:0] pc);
    exp_t e;
    e.instr = mem[pc[4:2]];
    e.pc    = pc;
    sb.push_back(e);
  endtask

  bit done = 1'b0;

  initial begin : monitor
    exp_t e;
    while (!done) begin
      @(negedge clk);
      if (reset && id_valid && id_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_delivery_pc", id_pc, 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          chk("sb_instr",    id_instr,    e.instr);
          chk("sb_pc",       id_pc,       e.pc);
          chk("sb_pc_plus4", id_pc_plus4, e.pc + 32'd4);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_valid"},    {31'b0, id_valid},    32'd0);
    chk({tag, "_instr"},    id_instr,             NOP);
    chk({tag, "_pc"},       id_pc,                32'd0);
    chk({tag, "_pc4"},      id_pc_plus4,          32'd0);
    chk({tag, "_fault"},    {31'b0, fetch_fault}, 32'd0);
    chk({tag, "_count"},    fetch_count,          32'd0);
    chk({tag, "_addr"},     imem_addr,            32'd0);
  endtask

  initial begin : stim
    reset = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; id_ready = 1'b1;
    tick(); tick();
    chk_reset_vals("rst");

    // Boot and first two sequential fetches.
    push(32'h0); push(32'h4);
    reset = 1'b1;
    tick();                                   // BOOT cycle
    chk("boot_idle_valid", {31'b0, id_valid}, 32'd0);
    tick();                                   // word @0 captured
    chk("first_instr", id_instr, 32'h0094_0333);
    tick();                                   // word @4
    tick();                                   // word @8, pc=12
    id_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_instr", id_instr, 32'h035a_02b3);
      chk("stall_pc", id_pc, 32'h8);
      chk("stall_addr", imem_addr, 32'hC);
      chk("stall_count", fetch_count, 32'd2);
    end

    // Redirect while stalled flushes the slot.
    redirect_valid = 1'b1; redirect_pc = 32'h10;
    tick();
    redirect_valid = 1'b0; id_ready = 1'b1;
    chk("flush_valid", {31'b0, id_valid}, 32'd0);
    chk("flush_instr", id_instr, NOP);
    chk("redir_addr", imem_addr, 32'h10);
    push(32'h10); push(32'h14); push(32'h18); push(32'h1C);
    tick();
    chk("redir_target_instr", id_instr, 32'h0019_ceb3);
    tick(); tick(); tick();                   // 0x14, 0x18, 0x1C
    tick();                                   // pc=0x20 faults
    chk("range_fault", {31'b0, fetch_fault}, 32'd1);
    chk("range_fault_valid", {31'b0, id_valid}, 32'd0);
    chk("range_fault_instr", id_instr, NOP);
    tick(); tick();
    chk("halt_no_fetch", {31'b0, id_valid}, 32'd0);
    chk("halt_pc_held", imem_addr, 32'h20);
    chk("halt_count", fetch_count, 32'd6);

    // Redirect out of HALT resumes fetching at 0.
    push(32'h0); push(32'h4);
    redirect_valid = 1'b1; redirect_pc = 32'h0;
    tick();
    redirect_valid = 1'b0;
    tick();
    chk("resume_instr", id_instr, 32'h0094_0333);
    tick();                                   // slot = word @4, ready high
    chk("fault_sticky", {31'b0, fetch_fault}, 32'd1);

    // Redirect to a misaligned target coincident with a handshake.
    redirect_valid = 1'b1; redirect_pc = 32'h6;
    tick();
    redirect_valid = 1'b0;
    chk("hs_with_redirect_count", fetch_count, 32'd8);
    tick();                                   // pc=6 faults
    chk("misalign_valid", {31'b0, id_valid}, 32'd0);
    tick();
    chk("misalign_halt_addr", imem_addr, 32'h6);

    // Reset pulse mid-stall.
    id_ready = 1'b0;
    tick();
    reset = 1'b0;
    #1;
    chk_reset_vals("rst_pulse");
    tick();

    // Random backpressure over the whole memory.
    for (int a = 0; a < 32; a += 4) push(32'(a));
    reset = 1'b1;
    for (int i = 0; i < 40; i++) begin
      id_ready = 1'($urandom_range(0, 1));
      tick();
    end
    id_ready = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    chk("rand_count", fetch_count, 32'd8);
    chk("rand_sb_empty", 32'(sb.size()), 32'd0);
    chk("rand_fault", {31'b0, fetch_fault}, 32'd1);

    done = 1'b1;
    @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1);
  end

endmodule : tb_instruction_fetch_stage
`default_nettype wire
